// File: rtl/overlay_in_framer.sv
// Purpose : buffers a bursty valid/ready word stream into whole PE-array frames
//           (PE_NUM*LOAD_NUM words) and replays each frame as one unbroken burst.
// Latency : last word accepted at edge T -> first output word after edge T+2,
//           last output word after edge T+FRAME_LEN+1 (drain side idle).
// Backpressure: s_ready drops only while the bank selected for writing is still
//           full, i.e. both ping-pong banks hold complete frames awaiting drain.
//
// Ports
//   clk            clock, all logic on posedge
//   rst            asynchronous active-high reset
//   s_valid        source word valid
//   s_ready        framer can accept a word (registered state only)
//   s_data         source word (DATA_W bits, packed I/Q)
//   din_overlay_v  frame word valid toward the PE array
//   din_overlay    frame word toward the PE array
//   busy           any bank full or drain FSM not idle
//   frames_sent    count of frames fully emitted, wraps at 16 bits

module overlay_in_framer #(
   parameter int DATA_W   = 32,
   parameter int PE_NUM   = 8,
   parameter int LOAD_NUM = 64,
   parameter int GAP_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              din_overlay_v,
   output logic [DATA_W-1:0] din_overlay,
   output logic              busy,
   output logic [15:0]       frames_sent
);

   localparam int FRAME_LEN = PE_NUM * LOAD_NUM;
   localparam int CNT_W     = $clog2(FRAME_LEN) + 1;
   localparam int ADDR_W    = $clog2(FRAME_LEN);
   localparam int MEM_DEPTH = 2 << ADDR_W;
   localparam int GAP_W     = $clog2(GAP_CYC + 1);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   // Both banks live in one array; the bank bit is the address MSB.
   logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];

   logic [1:0]        r_full;
   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [CNT_W-1:0]  r_wr_cnt;
   logic [CNT_W-1:0]  r_rd_cnt;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic              r_live;
   state_t            r_state;
   logic              r_dout_v;
   logic [DATA_W-1:0] r_dout;
   logic [15:0]       r_frames_sent;

   logic              w_accept;
   logic              w_wr_last;
   logic              w_rd_last;
   logic [1:0]        w_set;
   logic [1:0]        w_clr;
   logic [ADDR_W:0]   w_wr_addr;
   logic [ADDR_W:0]   w_rd_addr;

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   // r_live holds s_ready low throughout reset and for the release edge,
   // so the source never sees a ready that the flags do not back up.
   assign s_ready   = r_live & ~r_full[r_wr_bank];
   assign w_accept  = s_valid & s_ready;
   assign w_wr_last = w_accept && (r_wr_cnt == LAST_IDX);
   assign w_wr_addr = {r_wr_bank, r_wr_cnt[ADDR_W-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_live    <= 1'b0;
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            if (w_wr_last) begin
               r_wr_cnt  <= '0;
               r_wr_bank <= ~r_wr_bank;
            end else begin
               r_wr_cnt <= r_wr_cnt + 1'b1;
            end
         end
      end
   end

   // Storage has no reset: a discarded partial frame is harmless because
   // only banks flagged full are ever read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[w_wr_addr] <= s_data;
      end
   end

   // ------------------------------------------------------------------
   // Bank-full flags
   // ------------------------------------------------------------------
   // The writer only touches a non-full bank and the reader only a full
   // one, so a set and a clear on the same edge always hit different banks.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (w_wr_last) begin
         w_set[r_wr_bank] = 1'b1;
      end
      if (w_rd_last) begin
         w_clr[r_rd_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= '0;
      end else begin
         r_full <= (r_full | w_set) & ~w_clr;
      end
   end

   // ------------------------------------------------------------------
   // Drain FSM: IDLE -> STREAM -> GAP -> IDLE
   // ------------------------------------------------------------------
   assign w_rd_last = (r_state == ST_STREAM) && (r_rd_cnt == LAST_IDX);
   assign w_rd_addr = {r_rd_bank, r_rd_cnt[ADDR_W-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rd_bank     <= 1'b0;
         r_rd_cnt      <= '0;
         r_gap_cnt     <= '0;
         r_dout_v      <= 1'b0;
         r_dout        <= '0;
         r_frames_sent <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_dout_v <= 1'b0;
               r_dout   <= '0;
               if (r_full[r_rd_bank]) begin
                  r_rd_cnt <= '0;
                  r_state  <= ST_STREAM;
               end
            end

            ST_STREAM: begin
               // Output register doubles as the memory read register.
               r_dout_v <= 1'b1;
               r_dout   <= r_mem[w_rd_addr];
               if (w_rd_last) begin
                  r_rd_cnt      <= '0;
                  r_rd_bank     <= ~r_rd_bank;
                  r_frames_sent <= r_frames_sent + 16'd1;
                  r_gap_cnt     <= '0;
                  r_state       <= ST_GAP;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end

            ST_GAP: begin
               // Forced low cycles let the array's valid counter restart at 0.
               r_dout_v <= 1'b0;
               r_dout   <= '0;
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end

            default: begin
               r_dout_v <= 1'b0;
               r_dout   <= '0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign din_overlay_v = r_dout_v;
   assign din_overlay   = r_dout;
   assign frames_sent   = r_frames_sent;
   assign busy          = r_full[0] | r_full[1] | (r_state != ST_IDLE);

endmodule
